// File: rtl/opb_arb_pkg.sv
// opb_arb_pkg: shared widths, FSM state encoding and helpers for the OPB request arbiter
package opb_arb_pkg;

    localparam int OPB_AW = 32;
    localparam int OPB_DW = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/opb_rr_picker.sv
// opb_rr_picker: combinational round-robin select of the first request at or after the pointer
module opb_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    // scan from farthest to nearest so the request closest to the pointer wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                idx   = IW'((int'(ptr) + k) % NUM_REQ);
                valid = 1'b1;
            end
        end
    end

    assign gnt = valid ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/opb_req_arbiter.sv
// opb_req_arbiter: round-robin sharing of one OPB master port among NUM_REQ requesters
module opb_req_arbiter
    import opb_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 16,
    parameter int RETRY_MAX = 3
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*OPB_AW-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_rnw,
    input  logic [NUM_REQ*BE_W-1:0]   req_be,
    input  logic [NUM_REQ*OPB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic [OPB_DW-1:0]         rdata,
    output logic                      busy,
    output logic [0:OPB_AW-1]         M_ABus,
    output logic [0:BE_W-1]           M_BE,
    output logic [0:OPB_DW-1]         M_DBus,
    output logic                      M_RNW,
    output logic                      M_select,
    output logic                      M_seqAddr,
    input  logic [0:OPB_DW-1]         Sl_DBus,
    input  logic                      Sl_xferAck,
    input  logic                      Sl_errAck,
    input  logic                      Sl_retry,
    input  logic                      Sl_toutSup
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int TW = idx_w(TIMEOUT);
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

    arb_state_e          state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       g_q, g_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [OPB_AW-1:0]   addr_q, addr_d;
    logic                rnw_q, rnw_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [OPB_DW-1:0]   wdata_q, wdata_d;
    logic [OPB_DW-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [TW-1:0]       tout_q, tout_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_valid;
    logic                sel;

    opb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // state and latched-transaction registers; async reset drops M_select at once
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            retry_q <= '0;
            tout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            retry_q <= retry_d;
            tout_q  <= tout_d;
        end
    end

    // next state: grant, OPB handshake priority (ack > errAck > retry > timeout), completion
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        retry_d = retry_q;
        tout_d  = tout_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_XFER;
                    g_d     = pick_idx;
                    gnt_d   = pick_gnt;
                    addr_d  = req_addr[pick_idx*OPB_AW +: OPB_AW];
                    rnw_d   = req_rnw[pick_idx];
                    be_d    = req_be[pick_idx*BE_W +: BE_W];
                    wdata_d = req_wdata[pick_idx*OPB_DW +: OPB_DW];
                    rdata_d = '0;
                    err_d   = 1'b0;
                    retry_d = '0;
                    tout_d  = '0;
                end
            end
            ST_XFER: begin
                if (Sl_xferAck) begin
                    state_d = ST_DONE;
                    rdata_d = rnw_q ? Sl_DBus : '0;
                end else if (Sl_errAck) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else if (Sl_retry) begin
                    if (retry_q < RW'(RETRY_MAX)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end else if (!Sl_toutSup) begin
                    if (tout_q == TW'(TIMEOUT - 1)) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end else begin
                        tout_d = tout_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                tout_d  = '0;
                state_d = ST_XFER;
            end
            ST_DONE: begin
                ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                retry_d = '0;
                tout_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sel       = (state_q == ST_XFER);
    assign M_select  = sel;
    assign M_seqAddr = 1'b0;
    assign M_ABus    = sel ? addr_q : '0;
    assign M_BE      = sel ? be_q : '0;
    assign M_DBus    = (sel && !rnw_q) ? wdata_q : '0;
    assign M_RNW     = sel & rnw_q;
    assign busy      = (state_q != ST_IDLE);
    assign ack       = (state_q == ST_DONE) ? gnt_q : '0;
    assign err       = (state_q == ST_DONE && err_q) ? gnt_q : '0;
    assign rdata     = (state_q == ST_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_opb_req_arbiter.sv
// tb_opb_req_arbiter: directed self-checking bench for the OPB request arbiter
module tb_opb_req_arbiter;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    req = '0;
    logic [127:0]  req_addr = '0;
    logic [3:0]    req_rnw = '0;
    logic [15:0]   req_be = '0;
    logic [127:0]  req_wdata = '0;
    logic [3:0]    ack, err;
    logic [31:0]   rdata;
    logic          busy;
    logic [0:31]   M_ABus;
    logic [0:3]    M_BE;
    logic [0:31]   M_DBus;
    logic          M_RNW, M_select, M_seqAddr;
    logic [0:31]   Sl_DBus = '0;
    logic          Sl_xferAck = 1'b0, Sl_errAck = 1'b0, Sl_retry = 1'b0, Sl_toutSup = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr [4] = '{32'h0000_0010, 32'h0000_0004, 32'h0000_0020, 32'h0000_0300};

    opb_req_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .RETRY_MAX(3)) dut (
        .OPB_Clk    (clk),
        .OPB_Rst_n  (rst_n),
        .req        (req),
        .req_addr   (req_addr),
        .req_rnw    (req_rnw),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .ack        (ack),
        .err        (err),
        .rdata      (rdata),
        .busy       (busy),
        .M_ABus     (M_ABus),
        .M_BE       (M_BE),
        .M_DBus     (M_DBus),
        .M_RNW      (M_RNW),
        .M_select   (M_select),
        .M_seqAddr  (M_seqAddr),
        .Sl_DBus    (Sl_DBus),
        .Sl_xferAck (Sl_xferAck),
        .Sl_errAck  (Sl_errAck),
        .Sl_retry   (Sl_retry),
        .Sl_toutSup (Sl_toutSup)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            req_addr[32*i +: 32] = exp_addr[i];
            req_be[4*i +: 4]     = 4'hF;
            req_wdata[32*i +: 32] = 32'h1111_0000 + i;
        end
        req_rnw = 4'b1011;
        req_be[8 +: 4] = 4'h3;
        req_wdata[64 +: 32] = 32'hDEAD_BEEF;
        tick();
        tick();
        check("reset_select", {31'd0, M_select}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ack", {28'd0, ack}, 32'd0);
        rst_n = 1'b1;
        tick();

        // single read by requester 1
        req = 4'b0010;
        tick();
        check("rd_select", {31'd0, M_select}, 32'd1);
        check("rd_abus", M_ABus, 32'h0000_0004);
        check("rd_rnw", {31'd0, M_RNW}, 32'd1);
        check("rd_dbus_zero", M_DBus, 32'd0);
        tick();
        check("rd_select_hold", {31'd0, M_select}, 32'd1);
        Sl_xferAck = 1'b1;
        Sl_DBus = 32'hB00B_0100;
        tick();
        check("rd_ack", {28'd0, ack}, 32'b0010);
        check("rd_err", {28'd0, err}, 32'd0);
        check("rd_rdata", rdata, 32'hB00B_0100);
        check("rd_done_select", {31'd0, M_select}, 32'd0);
        check("rd_done_busy", {31'd0, busy}, 32'd1);
        Sl_xferAck = 1'b0;
        Sl_DBus = '0;
        req = '0;
        tick();
        check("rd_idle_ack", {28'd0, ack}, 32'd0);
        check("rd_idle_busy", {31'd0, busy}, 32'd0);

        // round robin from pointer 0 with all requesters active
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req = 4'b1111;
        Sl_xferAck = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_abus_%0d", i), M_ABus, exp_addr[i % 4]);
            tick();
            check($sformatf("rr_ack_%0d", i), {28'd0, ack}, 32'd1 << (i % 4));
            tick();
        end
        Sl_xferAck = 1'b0;
        req = '0;
        tick();

        // write by requester 2 with two retries
        req = 4'b0100;
        tick();
        check("rt_abus0", M_ABus, 32'h0000_0020);
        check("rt_dbus0", M_DBus, 32'hDEAD_BEEF);
        check("rt_be0", {28'd0, M_BE}, 32'h3);
        check("rt_rnw0", {31'd0, M_RNW}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            Sl_retry = 1'b1;
            tick();
            check($sformatf("rt_gap_select_%0d", i), {31'd0, M_select}, 32'd0);
            check($sformatf("rt_gap_abus_%0d", i), M_ABus, 32'd0);
            Sl_retry = 1'b0;
            tick();
            check($sformatf("rt_reissue_select_%0d", i), {31'd0, M_select}, 32'd1);
            check($sformatf("rt_reissue_abus_%0d", i), M_ABus, 32'h0000_0020);
        end
        Sl_xferAck = 1'b1;
        tick();
        check("rt_ack", {28'd0, ack}, 32'b0100);
        check("rt_err", {28'd0, err}, 32'd0);
        Sl_xferAck = 1'b0;
        req = '0;
        tick();

        // retry on every issue exhausts after 1 + RETRY_MAX issues
        req = 4'b0001;
        Sl_retry = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rx_select_%0d", i), {31'd0, M_select}, 32'd1);
            tick();
            check($sformatf("rx_gap_%0d", i), {31'd0, M_select}, 32'd0);
        end
        tick();
        check("rx_select_last", {31'd0, M_select}, 32'd1);
        check("rx_no_ack_yet", {28'd0, ack}, 32'd0);
        tick();
        check("rx_ack", {28'd0, ack}, 32'b0001);
        check("rx_err", {28'd0, err}, 32'b0001);
        check("rx_rdata", rdata, 32'd0);
        Sl_retry = 1'b0;
        req = '0;
        tick();

        // no slave response: error after TIMEOUT select cycles
        req = 4'b1000;
        tick();
        for (int i = 0; i < 16; i++) begin
            check($sformatf("to_select_%0d", i), {31'd0, M_select}, 32'd1);
            tick();
        end
        check("to_ack", {28'd0, ack}, 32'b1000);
        check("to_err", {28'd0, err}, 32'b1000);
        check("to_rdata", rdata, 32'd0);
        req = '0;
        tick();

        // timeout suppressed for 40 cycles, then a successful read
        req = 4'b0010;
        Sl_toutSup = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) tick();
        check("ts_select", {31'd0, M_select}, 32'd1);
        check("ts_no_ack", {28'd0, ack}, 32'd0);
        Sl_xferAck = 1'b1;
        Sl_DBus = 32'h1234_5678;
        tick();
        check("ts_ack", {28'd0, ack}, 32'b0010);
        check("ts_err", {28'd0, err}, 32'd0);
        check("ts_rdata", rdata, 32'h1234_5678);
        Sl_xferAck = 1'b0;
        Sl_toutSup = 1'b0;
        Sl_DBus = '0;
        req = '0;
        tick();

        // async reset in the middle of a transfer; pointer was 2, so restart proves it returned to 0
        req = 4'b1000;
        tick();
        check("ar_select_before", {31'd0, M_select}, 32'd1);
        check("ar_abus_before", M_ABus, 32'h0000_0300);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_select_now", {31'd0, M_select}, 32'd0);
        check("ar_busy_now", {31'd0, busy}, 32'd0);
        check("ar_ack_now", {28'd0, ack}, 32'd0);
        req = 4'b1001;
        tick();
        check("ar_held_select", {31'd0, M_select}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("ar_restart_select", {31'd0, M_select}, 32'd1);
        check("ar_restart_abus", M_ABus, 32'h0000_0010);
        check("ar_restart_no_ack", {28'd0, ack}, 32'd0);
        Sl_xferAck = 1'b1;
        tick();
        check("ar_ack", {28'd0, ack}, 32'b0001);
        Sl_xferAck = 1'b0;
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
